// File: rtl/bht_btb_predictor.sv
// ---------------------------------------------------------------------------
// bht_btb_predictor
//   Direct-mapped branch target buffer with a per-entry saturating direction
//   counter. IF looks up the BTB to pick the next fetch PC. EX resolves
//   control-flow instructions, trains the BTB, and raises a flush when the
//   instruction already in ID is not the true successor.
//
// Parameters
//   INDEX_W  BTB index width (2^INDEX_W entries, index = pc[INDEX_W+1:2])
//   CTR_W    direction counter width (1..4)
//   CNT_W    statistics counter width
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_IF_pc, i_IF_inst          fetch-stage PC and instruction
//   i_ID_pc                     PC currently in decode (predicted successor)
//   i_EX_pc, i_EX_pc_four       execute-stage PC and PC+4
//   i_EX_inst, i_EX_valid       execute instruction, 0 = bubble
//   i_alu_data, i_brc_taken     resolved target and B-type outcome
//   i_stat_clr                  synchronous clear of statistics
//   o_flush, o_next_pc          mispredict flush and next fetch PC
//   o_branch_cnt, o_mispred_cnt resolved CF count and flush count
// ---------------------------------------------------------------------------
module bht_btb_predictor #(
  parameter int INDEX_W = 10,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_IF_pc,
  input  logic [31:0]       i_ID_pc,
  input  logic [31:0]       i_EX_pc,
  input  logic [31:0]       i_EX_pc_four,
  input  logic [31:0]       i_IF_inst,
  input  logic [31:0]       i_EX_inst,
  input  logic [31:0]       i_alu_data,
  input  logic              i_brc_taken,
  input  logic              i_EX_valid,
  input  logic              i_stat_clr,
  output logic              o_flush,
  output logic [31:0]       o_next_pc,
  output logic [CNT_W-1:0]  o_branch_cnt,
  output logic [CNT_W-1:0]  o_mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  localparam logic [CTR_W-1:0] CTR_ONE     = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX     = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_ONE;

  typedef enum logic [4:0] {
    OP_BRANCH = 5'b11000,
    OP_JALR   = 5'b11001,
    OP_JAL    = 5'b11011
  } cf_op_e;

  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [29:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   mispred_cnt_q;

  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_br, if_jmp, if_cf, if_hit, pred_taken;
  logic               ex_br, ex_cf, ex_hit, actual_taken, update;
  logic [31:0]        pred_pc, true_pc;
  logic [CTR_W-1:0]   ctr_cur, ctr_nxt;

  assign if_idx = i_IF_pc[INDEX_W+1:2];
  assign if_tag = i_IF_pc[31:INDEX_W+2];
  assign ex_idx = i_EX_pc[INDEX_W+1:2];
  assign ex_tag = i_EX_pc[31:INDEX_W+2];

  // Lookup reads the registered array directly, so IF always sees the
  // pre-update entry when EX writes the same index in the same cycle.
  always_comb begin
    if_br      = (i_IF_inst[6:2] == OP_BRANCH);
    if_jmp     = (i_IF_inst[6:2] == OP_JAL) || (i_IF_inst[6:2] == OP_JALR);
    if_cf      = if_br | if_jmp;
    if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && if_cf;
    pred_taken = if_hit && (if_jmp || ctr_q[if_idx][CTR_W-1]);
    pred_pc    = pred_taken ? {target_q[if_idx], 2'b00} : i_IF_pc + 32'd4;
  end

  always_comb begin
    ex_br        = (i_EX_inst[6:2] == OP_BRANCH);
    ex_cf        = ex_br || (i_EX_inst[6:2] == OP_JAL) || (i_EX_inst[6:2] == OP_JALR);
    actual_taken = ex_br ? i_brc_taken : 1'b1;
    true_pc      = actual_taken ? i_alu_data : i_EX_pc_four;
    update       = i_EX_valid && ex_cf;
    o_flush      = update && (true_pc != i_ID_pc);
    o_next_pc    = o_flush ? true_pc : pred_pc;
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ctr_cur      = ctr_q[ex_idx];
    ctr_nxt      = ctr_cur;
    if (!ex_hit) begin
      ctr_nxt = actual_taken ? CTR_WEAK_T : CTR_WEAK_NT;
    end else if (actual_taken) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_ONE;
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (update) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= i_alu_data[31:2];
      ctr_q[ex_idx]    <= ctr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (i_stat_clr) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (update)  branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
      if (o_flush) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

  logic unused_ok;
  assign unused_ok = ^{i_IF_inst[31:7], i_IF_inst[1:0], i_EX_inst[31:7],
                       i_EX_inst[1:0], i_EX_pc[1:0]};

endmodule

// File: tb/tb_bht_btb_predictor.sv
module tb_bht_btb_predictor;
  localparam int INDEX_W = 10;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 8;
  localparam int NENT    = 1 << INDEX_W;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int CTR_MAXV = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);

  localparam logic [31:0] I_B    = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_ALU  = 32'h0000_0033;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      if_pc, id_pc, ex_pc, ex_pc_four, if_inst, ex_inst, alu;
  logic             brc_taken, ex_valid, stat_clr;
  logic             flush;
  logic [31:0]      next_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  bht_btb_predictor #(.INDEX_W(INDEX_W), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_IF_pc(if_pc), .i_ID_pc(id_pc), .i_EX_pc(ex_pc), .i_EX_pc_four(ex_pc_four),
    .i_IF_inst(if_inst), .i_EX_inst(ex_inst), .i_alu_data(alu),
    .i_brc_taken(brc_taken), .i_EX_valid(ex_valid), .i_stat_clr(stat_clr),
    .o_flush(flush), .o_next_pc(next_pc),
    .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one record per BTB slot, counters as plain integers.
  bit          m_vld [NENT];
  logic [31:0] m_tag [NENT];
  logic [31:0] m_tgt [NENT];
  int          m_ctr [NENT];
  int          m_bcnt, m_mcnt;
  logic        e_flush;

  function automatic int kind(input logic [31:0] inst);
    logic [4:0] op;
    op = inst[6:2];
    if (op == 5'd24) return 1;       // conditional branch
    if (op == 5'd27) return 2;       // jal
    if (op == 5'd25) return 3;       // jalr
    return 0;
  endfunction

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NENT; i++) begin
      m_vld[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic drive_if(input logic [31:0] pc, input logic [31:0] inst);
    if_pc = pc; if_inst = inst;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] target, input logic tk, input logic [31:0] id);
    ex_valid = v; ex_pc = pc; ex_pc_four = pc + 32'd4; ex_inst = inst;
    alu = target; brc_taken = tk; id_pc = id;
  endtask

  // Compare combinational outputs against the model before the edge.
  task automatic eval();
    int ik, ii, ek;
    bit hit, ptk, atk;
    logic [31:0] pred, tpc;
    @(negedge clk);
    ik  = kind(if_inst);
    ii  = slot(if_pc);
    hit = (ik != 0) && m_vld[ii] && (m_tag[ii] == (if_pc >> (INDEX_W + 2)));
    ptk = hit && (ik >= 2 || m_ctr[ii] >= CTR_HALF);
    pred = ptk ? m_tgt[ii] : if_pc + 32'd4;
    ek  = kind(ex_inst);
    atk = (ek == 1) ? brc_taken : 1'b1;
    tpc = atk ? alu : ex_pc + 32'd4;
    e_flush = ex_valid && (ek != 0) && (tpc != id_pc);
    check("flush",   {31'd0, flush}, {31'd0, e_flush});
    check("next_pc", next_pc, e_flush ? tpc : pred);
  endtask

  // Advance the model across the edge and compare the statistics after it.
  task automatic commit();
    int ek, ei;
    bit atk, upd;
    ek  = kind(ex_inst);
    ei  = slot(ex_pc);
    atk = (ek == 1) ? brc_taken : 1'b1;
    upd = ex_valid && (ek != 0);
    if (upd) begin
      if (m_vld[ei] && m_tag[ei] == (ex_pc >> (INDEX_W + 2))) begin
        if (atk) m_ctr[ei] = (m_ctr[ei] < CTR_MAXV) ? m_ctr[ei] + 1 : CTR_MAXV;
        else     m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
      end else begin
        m_vld[ei] = 1;
        m_tag[ei] = ex_pc >> (INDEX_W + 2);
        m_ctr[ei] = atk ? CTR_HALF : CTR_HALF - 1;
      end
      m_tgt[ei] = alu & ~32'd3;
    end
    if (stat_clr) begin
      m_bcnt = 0; m_mcnt = 0;
    end else begin
      if (upd)     m_bcnt = (m_bcnt + 1) % CNT_MOD;
      if (e_flush) m_mcnt = (m_mcnt + 1) % CNT_MOD;
    end
    @(posedge clk);
    #1;
    check("branch_cnt",  32'(branch_cnt),  32'(m_bcnt));
    check("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
  endtask

  task automatic step();
    eval();
    commit();
  endtask

  logic [31:0] pc_pool [8] = '{32'h100, 32'h1100, 32'h2100, 32'h104,
                               32'h200, 32'h400, 32'hFFFF_FFFC, 32'h3000};
  logic [31:0] tg_pool [6] = '{32'h200, 32'h104, 32'h3000, 32'h1104, 32'h0, 32'h202};
  logic [31:0] op_pool [4] = '{I_B, I_JAL, I_JALR, I_ALU};

  function automatic logic [31:0] rnd_inst();
    return ($urandom() & 32'hFFFF_FF80) | op_pool[$urandom_range(0, 3)];
  endfunction

  initial begin
    logic [31:0] rpc, rtg, rid;
    int guard;
    rst_n = 1'b0; stat_clr = 1'b0;
    drive_if(32'h0, 32'h0);
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    model_clear();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty BTB: fall-through prediction, no flush, zero statistics.
    drive_if(32'h100, I_B);
    eval();
    check("rst_next_pc", next_pc, 32'h104);
    check("rst_flush", {31'd0, flush}, 32'd0);
    commit();
    check("rst_bcnt", 32'(branch_cnt), 32'd0);

    // First taken branch: flush redirects, then allocation predicts taken.
    drive_ex(1'b1, 32'h100, I_B, 32'h200, 1'b1, 32'h104);
    eval();
    check("alloc_flush_pc", next_pc, 32'h200);
    commit();
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    eval();
    check("alloc_pred", next_pc, 32'h200);
    check("alloc_bcnt", 32'(branch_cnt), 32'd1);
    check("alloc_mcnt", 32'(mispred_cnt), 32'd1);
    commit();

    // Saturate up, then walk down to strongly not-taken.
    for (int i = 0; i < 6; i++) begin
      drive_ex(1'b1, 32'h100, I_B, 32'h200, (i < 3), 32'h200);
      step();
    end
    check("sat_ctr_model", 32'(m_ctr[slot(32'h100)]), 32'd0);
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    eval();
    check("nt_pred", next_pc, 32'h104);
    commit();

    // Alias at the same index with a different tag misses.
    drive_if(32'h1100, I_B);
    eval();
    check("alias_miss", next_pc, 32'h1104);
    commit();
    drive_ex(1'b1, 32'h1100, I_JAL, 32'h3000, 1'b0, 32'h1104);
    step();
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive_if(32'h1100, I_JAL);
    eval();
    check("jal_pred", next_pc, 32'h3000);
    commit();
    // Drive the counter to zero with not-taken branches; JAL still predicts taken.
    for (int i = 0; i < 3; i++) begin
      drive_if(32'h1100, I_B);
      drive_ex(1'b1, 32'h1100, I_B, 32'h3000, 1'b0, 32'h1104);
      step();
    end
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive_if(32'h1100, I_JAL);
    eval();
    check("jal_pred_ctr0", next_pc, 32'h3000);
    commit();

    // Bubble in EX: no flush, no training.
    drive_ex(1'b0, 32'h100, I_JALR, 32'h5000, 1'b1, 32'h9999_0000);
    eval();
    check("bubble_flush", {31'd0, flush}, 32'd0);
    commit();

    // Statistics wrap.
    guard = 0;
    drive_ex(1'b1, 32'h400, I_JALR, 32'h800, 1'b1, 32'h800);
    while (m_bcnt != CNT_MOD - 1 && guard < 2 * CNT_MOD) begin
      step();
      guard++;
    end
    check("wrap_reach", 32'(m_bcnt), 32'(CNT_MOD - 1));
    step();
    check("wrap_zero", 32'(branch_cnt), 32'd0);

    // Clear wins over a simultaneous increment.
    drive_ex(1'b1, 32'h400, I_JALR, 32'h900, 1'b1, 32'h800);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_bcnt", 32'(branch_cnt), 32'd0);
    check("clr_mcnt", 32'(mispred_cnt), 32'd0);

    // Mid-run reset forgets learned entries.
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive_if(32'h1100, I_JAL);
    drive_ex(1'b1, 32'h400, I_JALR, 32'h900, 1'b1, 32'h800);
    step();
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #2;
    check("mrst_next_pc", next_pc, 32'h1104);
    check("mrst_bcnt", 32'(branch_cnt), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rpc = pc_pool[$urandom_range(0, 7)];
      rtg = tg_pool[$urandom_range(0, 5)];
      drive_if(pc_pool[$urandom_range(0, 7)], rnd_inst());
      case ($urandom_range(0, 2))
        0: rid = rpc + 32'd4;
        1: rid = rtg;
        default: rid = pc_pool[$urandom_range(0, 7)];
      endcase
      drive_ex(($urandom_range(0, 9) < 8), rpc, rnd_inst(), rtg, 1'($urandom()), rid);
      stat_clr = ($urandom_range(0, 99) == 0);
      step();
    end
    stat_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
